// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared widths and FSM state type for the memory burst reader
package memory_pkg;

    localparam int MEM_ELEM_WIDTH = 8;
    localparam int MEM_ADDR_WIDTH = 10;
    localparam int MEM_DEPTH      = 1024;
    localparam int MEM_LEN_WIDTH  = MEM_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/memory_burst_reader_if.sv
// rtl/memory_burst_reader_if.sv - request, memory read port and output stream of the burst reader
interface memory_burst_reader_if
    import memory_pkg::*;
#(
    parameter int ELEM_WIDTH = MEM_ELEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = MEM_LEN_WIDTH
);

    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [LEN_WIDTH-1:0]  req_len_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [ELEM_WIDTH-1:0] mem_data_i;
    logic [ELEM_WIDTH-1:0] data_o;
    logic                  data_valid_o;
    logic                  data_ready_i;
    logic                  data_last_o;
    logic                  busy_o;

    // master is the reader engine; slave is the requester / memory / consumer side
    modport master (
        input  req_addr_i, req_len_i, req_valid_i, mem_data_i, data_ready_i,
        output req_ready_o, mem_addr_o, data_o, data_valid_o, data_last_o, busy_o
    );

    modport slave (
        output req_addr_i, req_len_i, req_valid_i, mem_data_i, data_ready_i,
        input  req_ready_o, mem_addr_o, data_o, data_valid_o, data_last_o, busy_o
    );

endinterface

// File: rtl/memory_burst_reader.sv
// rtl/memory_burst_reader.sv - burst read engine streaming a combinational-read memory column
module memory_burst_reader
    import memory_pkg::*;
#(
    parameter int ELEM_WIDTH = MEM_ELEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = MEM_LEN_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    memory_burst_reader_if.master  bus
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [ELEM_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;

    logic accept;
    logic load;
    logic handshake;

    assign accept    = (state_q == IDLE) && bus.req_valid_i;
    assign handshake = valid_q && bus.data_ready_i;
    // The single output register refills whenever it is empty or being drained this cycle
    assign load      = (state_q == READ) && (remaining_q != '0) && (!valid_q || bus.data_ready_i);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (bus.req_len_i != '0)) state_d = READ;
            READ:    if (load && (remaining_q == LEN_WIDTH'(1))) state_d = DRAIN;
            DRAIN:   if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= bus.req_addr_i;
                remaining_q <= bus.req_len_i;
            end
            if (load) begin
                data_q      <= bus.mem_data_i;
                valid_q     <= 1'b1;
                last_q      <= (remaining_q == LEN_WIDTH'(1));
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - LEN_WIDTH'(1);
            end else if (handshake) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.mem_addr_o   = addr_q;
    assign bus.data_o       = data_q;
    assign bus.data_valid_o = valid_q;
    assign bus.data_last_o  = last_q;

    // Lengths beyond the memory depth silently wrap; flag them
    a_len_legal: assert property (@(posedge clk_i) disable iff (arst_i)
        accept |-> (bus.req_len_i <= LEN_WIDTH'(2 ** ADDR_WIDTH)));

endmodule

// File: tb/tb_memory_burst_reader.sv
// tb/tb_memory_burst_reader.sv - directed self-checking bench for memory_burst_reader
module tb_memory_burst_reader;
    import memory_pkg::*;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    memory_burst_reader_if bus ();

    logic [7:0] mem [0:1023];
    assign bus.mem_data_i = mem[bus.mem_addr_o];

    memory_burst_reader dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"},     32'(bus.data_valid_o), 32'd0);
        check({tag, "_last"},      32'(bus.data_last_o),  32'd0);
        check({tag, "_busy"},      32'(bus.busy_o),       32'd0);
        check({tag, "_req_ready"}, 32'(bus.req_ready_o),  32'd1);
    endtask

    task automatic send_req(input int addr, input int len);
        @(negedge clk);
        bus.req_addr_i  = addr[9:0];
        bus.req_len_i   = len[10:0];
        bus.req_valid_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0,1,0,1 over valid cycles; 2: random ready
    task automatic run_burst(input int addr, input int len, input int mode, input string tag);
        int idx = 0;
        int cyc = 0;
        int p = 0;
        int first = -1;
        logic [5:0] pat = 6'b101001;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        logic r;
        send_req(addr, len);
        check({tag, "_start_addr"}, 32'(bus.mem_addr_o), 32'(addr & 1023));
        while (idx < len && cyc < len * 4 + 20) begin
            if (cyc > 0) @(negedge clk);
            check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
            check({tag, "_req_ready_low"}, 32'(bus.req_ready_o), 32'd0);
            if (pv && !pr) begin
                check({tag, "_stall_valid"}, 32'(bus.data_valid_o), 32'd1);
                check({tag, "_stall_data"},  32'(bus.data_o), 32'(pd));
                check({tag, "_stall_last"},  32'(bus.data_last_o), 32'(pl));
            end
            if (bus.data_valid_o && first < 0) first = cyc;
            if (mode == 0) begin
                r = 1'b1;
            end else if (mode == 1) begin
                r = 1'b1;
                if (bus.data_valid_o) begin
                    if (p < 6) r = pat[p];
                    p++;
                end
            end else begin
                r = ($urandom_range(0, 3) != 0);
            end
            bus.data_ready_i = r;
            if (bus.data_valid_o && r) begin
                check({tag, "_data"}, 32'(bus.data_o), 32'((addr + idx) & 255));
                check({tag, "_last"}, 32'(bus.data_last_o), 32'(idx == len - 1));
                check({tag, "_mem_addr"}, 32'(bus.mem_addr_o), 32'((addr + idx + 1) & 1023));
                idx++;
            end
            pv = bus.data_valid_o;
            pr = r;
            pd = bus.data_o;
            pl = bus.data_last_o;
            cyc++;
        end
        check({tag, "_beat_count"}, 32'(idx), 32'(len));
        check({tag, "_first_latency"}, 32'(first), 32'd1);
        @(negedge clk);
        check_idle_outputs({tag, "_end"});
        bus.data_ready_i = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
        bus.req_addr_i   = '0;
        bus.req_len_i    = '0;
        bus.req_valid_i  = 1'b0;
        bus.data_ready_i = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check("reset_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        check("reset_data",     32'(bus.data_o),     32'd0);
        check_idle_outputs("reset");
        arst = 1'b0;

        run_burst(5, 4, 0, "basic");
        run_burst(1022, 4, 0, "wrap");
        run_burst(7, 3, 1, "stall");

        send_req(50, 0);
        check("len0_mem_addr", 32'(bus.mem_addr_o), 32'd50);
        check_idle_outputs("len0_accept");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("len0_hold");
        end

        bus.data_ready_i = 1'b1;
        send_req(0, 10);
        @(negedge clk);
        check("abort_beat0", 32'(bus.data_o), 32'h00);
        @(negedge clk);
        check("abort_beat1", 32'(bus.data_o), 32'h01);
        @(negedge clk);
        arst = 1'b1;
        #1;
        check("abort_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        check("abort_data",     32'(bus.data_o),     32'd0);
        check_idle_outputs("abort");
        @(negedge clk);
        check_idle_outputs("abort_held");
        arst = 1'b0;

        run_burst(100, 2, 0, "after_reset");

        run_burst(0, 1024, 2, "full");
        check("full_addr_return", 32'(bus.mem_addr_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
